ps2_byte_transmitter: RTL and testbench

- Device-side PS/2 frame generator for the keyboard FPGA.
- Accepts one scan-code byte at a time from the keyboard logic and serialises it onto the open-collector PS/2 bus as an 11-bit frame: start, 8 data LSB first, odd parity, stop.
- Generates the PS/2 clock itself and detects host inhibit.
- Its pulldown outputs are ORed with the power-on response block's pulldowns at the pad level; the two blocks never drive simultaneously because tx_valid is held low until the power-on response completes.

---
 rtl/ps2_byte_transmitter.sv | 150 +++++++++++++++
 tb/tb_ps2_byte_transmitter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_byte_transmitter.sv
// Device-side PS/2 frame generator: sends one byte as start, 8 data bits LSB first,
// odd parity and stop, and generates the bus clock through open-collector pulldowns.
module ps2_byte_transmitter #(
  parameter int HALF_PERIOD = 16,
  parameter int BIT_WIDTH   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_abort,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_pulldown,
  output logic       ps2_data_pulldown
);

  // state    | meaning
  // IDLE     | bus released, waiting for a byte
  // BIT_HIGH | clock released, data bit driven; inhibit checked on last cycle
  // BIT_LOW  | clock pulled low, host samples the data bit
  // GAP      | frame finished, bus released before the next byte
  // ABORT    | host inhibited the clock, frame dropped
  typedef enum logic [2:0] {IDLE, BIT_HIGH, BIT_LOW, GAP, ABORT} state_t;

  localparam logic [BIT_WIDTH-1:0] CNT_LAST = BIT_WIDTH'(HALF_PERIOD - 1);
  localparam logic [3:0]           LAST_BIT = 4'd10;

  state_t               state, state_nx;
  logic [BIT_WIDTH-1:0] counter, counter_nx;
  logic [3:0]           bit_idx, bit_idx_nx;
  logic [10:0]          frame, frame_nx;
  logic                 clk_m, clk_s, data_m, data_s;
  logic                 ready_en;
  logic                 clk_pd_nx, data_pd_nx, done_nx, abort_nx;
  logic                 cnt_last, transfer;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_m  <= 1'b1;
      clk_s  <= 1'b1;
      data_m <= 1'b1;
      data_s <= 1'b1;
    end else begin
      clk_m  <= ps2_clk_in;
      clk_s  <= clk_m;
      data_m <= ps2_data_in;
      data_s <= data_m;
    end
  end

  // Keeps tx_ready low while reset is asserted even though the synchronisers reset high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ready_en <= 1'b0;
    else      ready_en <= 1'b1;
  end

  assign tx_ready = ready_en && (state == IDLE) && clk_s && data_s;
  assign transfer = tx_valid && tx_ready;
  assign cnt_last = (counter == CNT_LAST);

  always_comb begin
    state_nx   = state;
    counter_nx = counter;
    bit_idx_nx = bit_idx;
    frame_nx   = frame;
    clk_pd_nx  = 1'b0;
    data_pd_nx = 1'b0;
    done_nx    = 1'b0;
    abort_nx   = 1'b0;
    unique case (state)
      IDLE: begin
        if (transfer) begin
          state_nx   = BIT_HIGH;
          counter_nx = '0;
          bit_idx_nx = '0;
          frame_nx   = {1'b1, ~^tx_data, tx_data, 1'b0};
          data_pd_nx = 1'b1;
        end
      end
      BIT_HIGH: begin
        data_pd_nx = ps2_data_pulldown;
        counter_nx = counter + BIT_WIDTH'(1);
        if (cnt_last) begin
          counter_nx = '0;
          if (!clk_s) begin
            state_nx   = ABORT;
            abort_nx   = 1'b1;
            data_pd_nx = 1'b0;
          end else begin
            state_nx  = BIT_LOW;
            clk_pd_nx = 1'b1;
          end
        end
      end
      BIT_LOW: begin
        clk_pd_nx  = 1'b1;
        data_pd_nx = ps2_data_pulldown;
        counter_nx = counter + BIT_WIDTH'(1);
        if (cnt_last) begin
          counter_nx = '0;
          clk_pd_nx  = 1'b0;
          if (bit_idx == LAST_BIT) begin
            state_nx   = GAP;
            done_nx    = 1'b1;
            data_pd_nx = 1'b0;
          end else begin
            state_nx   = BIT_HIGH;
            bit_idx_nx = bit_idx + 4'd1;
            data_pd_nx = ~frame[bit_idx_nx];
          end
        end
      end
      GAP: begin
        counter_nx = counter + BIT_WIDTH'(1);
        if (cnt_last) begin
          counter_nx = '0;
          state_nx   = IDLE;
        end
      end
      ABORT:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= IDLE;
      counter           <= '0;
      bit_idx           <= '0;
      frame             <= '0;
      ps2_clk_pulldown  <= 1'b0;
      ps2_data_pulldown <= 1'b0;
      tx_done           <= 1'b0;
      tx_abort          <= 1'b0;
    end else begin
      state             <= state_nx;
      counter           <= counter_nx;
      bit_idx           <= bit_idx_nx;
      frame             <= frame_nx;
      ps2_clk_pulldown  <= clk_pd_nx;
      ps2_data_pulldown <= data_pd_nx;
      tx_done           <= done_nx;
      tx_abort          <= abort_nx;
    end
  end

endmodule

// File: tb/tb_ps2_byte_transmitter.sv
// Bench for ps2_byte_transmitter: a bus monitor rebuilds each frame from the clock-low
// pulses and compares it against the frame queued when the byte was handed over.
module tb_ps2_byte_transmitter;
  logic       clk, rst;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready, tx_done, tx_abort;
  logic       ps2_clk_in, ps2_data_in, ps2_clk_pulldown, ps2_data_pulldown;

  ps2_byte_transmitter #(.HALF_PERIOD(4), .BIT_WIDTH(3)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_done(tx_done), .tx_abort(tx_abort), .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_pulldown(ps2_clk_pulldown), .ps2_data_pulldown(ps2_data_pulldown)
  );

  typedef struct {logic [10:0] frame; bit abort;} sb_t;
  typedef struct {logic [7:0] data; logic [10:0] frame;} vec_t;

  sb_t         sb[$];
  int          errors = 0, checks = 0;
  int          cyc = 0, done_cnt = 0, abort_cnt = 0, done_cyc = 0, abort_cyc = 0;
  int          nbits = 0, low_len = 0;
  logic        prev_cpd = 1'b0;
  logic [10:0] got = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bus monitor and scoreboard consumer.
  always @(negedge clk) begin
    if (!rst) begin
      nbits = 0; low_len = 0; prev_cpd = 1'b0;
    end else begin
      if (ps2_clk_pulldown) begin
        if (!prev_cpd) begin
          if (nbits < 11) got[nbits] = ~ps2_data_pulldown;
          nbits++;
        end
        low_len++;
      end else if (prev_cpd) begin
        chk("clk_low_len", low_len, 4);
        low_len = 0;
      end
      prev_cpd = ps2_clk_pulldown;
      if (tx_done) begin
        sb_t e;
        done_cnt++; done_cyc = cyc;
        chk("done_abort_excl", {31'd0, tx_abort}, 0);
        chk("sb_depth_done", sb.size(), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("frame_bits", got, e.frame);
          chk("frame_nbits", nbits, 11);
          chk("done_not_abort", {31'd0, e.abort}, 0);
        end
        nbits = 0;
      end
      if (tx_abort) begin
        sb_t e;
        abort_cnt++; abort_cyc = cyc;
        chk("sb_depth_abort", sb.size(), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("abort_expected", {31'd0, e.abort}, 1);
        end
        nbits = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) tick();
  endtask

  task automatic send_byte(input logic [7:0] d, input logic [10:0] f, input bit ab,
                           input bit hold, output int t0);
    int n;
    sb_t e;
    n = 0;
    tx_data = d; tx_valid = 1'b1;
    while (!tx_ready && n < 1000) begin tick(); n++; end
    chk("ready_wait", {31'd0, n < 1000}, 1);
    tick();
    tx_valid = hold;
    e.frame = f; e.abort = ab;
    sb.push_back(e);
    t0 = cyc;
    chk("start_bit_first_cycle", {30'd0, ps2_clk_pulldown, ps2_data_pulldown}, 32'b01);
  endtask

  task automatic wait_done(input int start);
    int n;
    n = 0;
    while (done_cnt == start && n < 1000) begin tick(); n++; end
    chk("done_seen", done_cnt - start, 1);
  endtask

  vec_t vecs[6];

  initial begin
    int t0, t1, base_d, base_a;
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, base_d, base_a;
    vecs[0] = '{8'h1C, 11'h438};
    vecs[1] = '{8'h01, 11'h402};
    vecs[2] = '{8'h80, 11'h500};
    vecs[3] = '{8'h5A, 11'h6B4};
    vecs[4] = '{8'hFF, 11'h7FE};
    vecs[5] = '{8'hC3, 11'h786};

    rst = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; ps2_clk_in = 1'b1; ps2_data_in = 1'b1;
    #3;
    chk("rst_ready", {31'd0, tx_ready}, 0);
    chk("rst_done", {31'd0, tx_done}, 0);
    chk("rst_abort", {31'd0, tx_abort}, 0);
    chk("rst_pulldowns", {30'd0, ps2_clk_pulldown, ps2_data_pulldown}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) tick();
    chk("ready_after_reset", {31'd0, tx_ready}, 1);

    // Single 0xAA frame: latency and ready recovery.
    base_d = done_cnt;
    send_byte(8'hAA, 11'h754, 1'b0, 1'b0, t0);
    wait_done(base_d);
    chk("done_latency", done_cyc - t0, 88);
    t1 = 0;
    while (!tx_ready && t1 < 100) begin tick(); t1++; end
    chk("ready_after_done", cyc - done_cyc, 4);

    foreach (vecs[i]) begin
      base_d = done_cnt;
      send_byte(vecs[i].data, vecs[i].frame, 1'b0, 1'b0, t0);
      wait_done(base_d);
    end

    // Back-to-back 0x00 then 0xFF with tx_valid held high.
    base_d = done_cnt;
    send_byte(8'h00, 11'h600, 1'b0, 1'b1, t0);
    send_byte(8'hFF, 11'h7FE, 1'b0, 1'b0, t1);
    chk("b2b_second_start", t1 - done_cyc, 5);
    wait_done(base_d + 1);
    chk("b2b_done_count", done_cnt - base_d, 2);

    // Host inhibit during bit 3 high phase.
    base_d = done_cnt; base_a = abort_cnt;
    send_byte(8'h5A, 11'h6B4, 1'b1, 1'b0, t0);
    wait_cyc(t0 + 24); ps2_clk_in = 1'b0;
    wait_cyc(t0 + 27);
    chk("pre_abort_pd", {31'd0, ps2_data_pulldown}, 1);
    wait_cyc(t0 + 28);
    chk("abort_pulse", {31'd0, tx_abort}, 1);
    chk("abort_release", {30'd0, ps2_clk_pulldown, ps2_data_pulldown}, 0);
    wait_cyc(t0 + 29);
    chk("abort_one_cycle", {31'd0, tx_abort}, 0);
    wait_cyc(t0 + 35);
    chk("ready_inhibited", {31'd0, tx_ready}, 0);
    wait_cyc(t0 + 40); ps2_clk_in = 1'b1;
    wait_cyc(t0 + 41);
    chk("ready_sync_lag", {31'd0, tx_ready}, 0);
    wait_cyc(t0 + 42);
    chk("ready_after_release", {31'd0, tx_ready}, 1);
    chk("abort_count", abort_cnt - base_a, 1);
    chk("no_done_on_abort", done_cnt - base_d, 0);

    // Host request-to-send holds data low while idle.
    base_d = done_cnt;
    ps2_data_in = 1'b0;
    repeat (3) tick();
    tx_data = 8'h01; tx_valid = 1'b1;
    repeat (6) begin
      tick();
      chk("rts_ready_low", {31'd0, tx_ready}, 0);
      chk("rts_bus_quiet", {30'd0, ps2_clk_pulldown, ps2_data_pulldown}, 0);
    end
    ps2_data_in = 1'b1;
    send_byte(8'h01, 11'h402, 1'b0, 1'b0, t0);
    wait_done(base_d);

    // Asynchronous reset during bit 5.
    base_d = done_cnt; base_a = abort_cnt;
    send_byte(8'h80, 11'h500, 1'b0, 1'b0, t0);
    wait_cyc(t0 + 42);
    chk("pre_reset_pd", {31'd0, ps2_data_pulldown}, 1);
    #2 rst = 1'b0;
    #1;
    chk("reset_pulldowns", {30'd0, ps2_clk_pulldown, ps2_data_pulldown}, 0);
    chk("reset_ready", {31'd0, tx_ready}, 0);
    chk("sb_stale", sb.size(), 1);
    if (sb.size() > 0) void'(sb.pop_front());
    repeat (3) tick();
    rst = 1'b1;
    repeat (2) tick();
    chk("reset_no_pulses", (done_cnt - base_d) + (abort_cnt - base_a), 0);
    send_byte(8'h1C, 11'h438, 1'b0, 1'b0, t0);
    wait_done(base_d);

    // Inhibit only during bit 9 low phase: must not abort.
    base_d = done_cnt; base_a = abort_cnt;
    send_byte(8'hC3, 11'h786, 1'b0, 1'b0, t0);
    wait_cyc(t0 + 76); ps2_clk_in = 1'b0;
    wait_cyc(t0 + 79); ps2_clk_in = 1'b1;
    wait_done(base_d);
    chk("low_phase_no_abort", abort_cnt - base_a, 0);

    repeat (8) tick();
    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
